// File: rtl/vde_cmd_arbiter.sv
// Command ingress and arbiter for vde_heap. It compacts per-lane commands into one FIFO,
// holds one multi-bump vector and a decay backlog, and issues one op per free heap cycle.
module vde_cmd_arbiter #(
    parameter int LANES        = 2,
    parameter int FIFO_DEPTH   = 256,
    parameter int VAR_W        = 32,
    parameter int BUMP_MAX     = 8,
    parameter int STARVE_LIMIT = 16,
    parameter int DECAY_W      = 4,
    localparam int CNT_W = $clog2(BUMP_MAX + 1),
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [LANES-1:0]          cmd_valid,
    input  logic [2*LANES-1:0]        cmd_op,
    input  logic [VAR_W*LANES-1:0]    cmd_var,
    input  logic [LANES-1:0]          cmd_val,
    output logic                      cmd_ready,
    input  logic                      mb_valid,
    input  logic [CNT_W-1:0]          mb_count,
    input  logic [VAR_W*BUMP_MAX-1:0] mb_vars,
    output logic                      mb_ready,
    input  logic                      decay,
    input  logic                      heap_busy,
    output logic                      h_valid,
    output logic [2:0]                h_op,
    output logic [VAR_W-1:0]          h_var,
    output logic                      h_val,
    output logic [CNT_W-1:0]          h_bump_count,
    output logic [VAR_W*BUMP_MAX-1:0] h_bump_vars,
    output logic [LVL_W-1:0]          fifo_level,
    output logic                      overflow_err,
    output logic                      idle
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [1:0]       op;
        logic [VAR_W-1:0] var_id;
        logic             val;
    } entry_t;

    entry_t                    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [CNT_W-1:0]          mb_cnt_q;
    logic [VAR_W*BUMP_MAX-1:0] mb_vars_q;
    logic [DECAY_W-1:0]        decay_cnt;
    logic [SW-1:0]             starve_cnt;

    logic [LANES-1:0]  lane_take;
    logic [PTR_W-1:0]  lane_slot [LANES];
    logic [2:0]        n_push;
    logic              sel_fifo, sel_mb, sel_decay, starve_hit, can_issue;
    entry_t            head;

    assign cmd_ready  = fifo_level <= LVL_W'(FIFO_DEPTH - LANES);
    assign idle       = (fifo_level == '0) && mb_ready && (decay_cnt == '0) && !heap_busy;
    assign head       = mem[rd_ptr];
    assign can_issue  = !heap_busy && !flush;
    assign starve_hit = !mb_ready && (starve_cnt >= SW'(STARVE_LIMIT));
    assign sel_fifo   = can_issue && (fifo_level != '0) && !starve_hit;
    assign sel_mb     = can_issue && !mb_ready && !sel_fifo;
    assign sel_decay  = can_issue && (decay_cnt != '0) && !sel_fifo && !sel_mb;

    // Lane compaction: each taken lane lands on the next free slot, lane 0 first.
    always_comb begin
        n_push = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_take[l] = cmd_ready && !flush && cmd_valid[l] && (cmd_op[2*l +: 2] != 2'd3);
            lane_slot[l] = wr_ptr + PTR_W'(n_push);
            if (lane_take[l]) n_push = n_push + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (lane_take[l]) begin
                mem[lane_slot[l]] <= '{op: cmd_op[2*l +: 2], var_id: cmd_var[VAR_W*l +: VAR_W],
                                       val: cmd_val[l]};
            end
        end
    end

    always_comb begin
        h_valid      = 1'b0;
        h_op         = 3'd0;
        h_var        = '0;
        h_val        = 1'b0;
        h_bump_count = '0;
        h_bump_vars  = '0;
        if (sel_fifo) begin
            h_valid = 1'b1;
            h_op    = {1'b0, head.op};
            h_var   = head.var_id;
            h_val   = (head.op == 2'd0) && head.val;
        end else if (sel_mb) begin
            h_valid      = 1'b1;
            h_op         = 3'd3;
            h_bump_count = mb_cnt_q;
            h_bump_vars  = mb_vars_q;
        end else if (sel_decay) begin
            h_valid = 1'b1;
            h_op    = 3'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            mb_ready     <= 1'b1;
            mb_cnt_q     <= '0;
            mb_vars_q    <= '0;
            decay_cnt    <= '0;
            starve_cnt   <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            mb_ready     <= 1'b1;
            mb_cnt_q     <= '0;
            mb_vars_q    <= '0;
            decay_cnt    <= '0;
            starve_cnt   <= '0;
            overflow_err <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(n_push);
            rd_ptr     <= rd_ptr + PTR_W'(sel_fifo);
            fifo_level <= fifo_level + LVL_W'(n_push) - LVL_W'(sel_fifo);
            if ((cmd_valid != '0) && !cmd_ready) overflow_err <= 1'b1;

            if (mb_ready) begin
                if (mb_valid && (mb_count != '0)) begin
                    mb_ready  <= 1'b0;
                    mb_cnt_q  <= mb_count;
                    mb_vars_q <= mb_vars;
                end
            end else if (sel_mb) begin
                mb_ready <= 1'b1;
            end

            // Starvation counts only FIFO wins that bypass a waiting vector.
            if (sel_mb) starve_cnt <= '0;
            else if (sel_fifo && !mb_ready) starve_cnt <= starve_cnt + SW'(1);

            if (decay && !sel_decay) begin
                if (decay_cnt == {DECAY_W{1'b1}}) overflow_err <= 1'b1;
                else decay_cnt <= decay_cnt + DECAY_W'(1);
            end else if (!decay && sel_decay) begin
                decay_cnt <= decay_cnt - DECAY_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_vde_cmd_arbiter.sv
// Scoreboard bench for vde_cmd_arbiter: expected heap ops are queued as stimulus is
// driven and popped by a monitor whenever the arbiter issues.
module tb_vde_cmd_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   cmd_valid = '0;
    logic [3:0]   cmd_op = '0;
    logic [63:0]  cmd_var = '0;
    logic [1:0]   cmd_val = '0;
    logic         cmd_ready;
    logic         mb_valid = 1'b0;
    logic [3:0]   mb_count = '0;
    logic [255:0] mb_vars = '0;
    logic         mb_ready;
    logic         decay = 1'b0;
    logic         heap_busy = 1'b0;
    logic         h_valid;
    logic [2:0]   h_op;
    logic [31:0]  h_var;
    logic         h_val;
    logic [3:0]   h_bump_count;
    logic [255:0] h_bump_vars;
    logic [8:0]   fifo_level;
    logic         overflow_err;
    logic         idle;

    int checks = 0;
    int errors = 0;
    int n_pushed = 0;
    int n_popped = 0;
    logic [39:0] exp_q[$];

    vde_cmd_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_var(cmd_var), .cmd_val(cmd_val),
        .cmd_ready(cmd_ready), .mb_valid(mb_valid), .mb_count(mb_count), .mb_vars(mb_vars),
        .mb_ready(mb_ready), .decay(decay), .heap_busy(heap_busy), .h_valid(h_valid),
        .h_op(h_op), .h_var(h_var), .h_val(h_val), .h_bump_count(h_bump_count),
        .h_bump_vars(h_bump_vars), .fifo_level(fifo_level), .overflow_err(overflow_err),
        .idle(idle)
    );

    always #5 clk = ~clk;

    // Monitor: every issued op must match the oldest expected op.
    always @(negedge clk) begin
        logic [39:0] got, e;
        if (rst_n && h_valid) begin
            got = {h_op, h_var, h_val, h_bump_count};
            checks++;
            if (heap_busy) begin
                errors++;
                $display("FAIL issue_while_busy: h_op=%0d issued with heap_busy=1", h_op);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got op=%0d var=%0d, expected nothing", h_op, h_var);
            end else begin
                e = exp_q.pop_front();
                if (got !== e)
                    $display("FAIL issue_order: got op=%0d var=%0d val=%0d cnt=%0d, expected op=%0d var=%0d val=%0d cnt=%0d",
                             got[39:37], got[36:5], got[4], got[3:0], e[39:37], e[36:5], e[4], e[3:0]);
                if (got !== e) errors++;
            end
            if (h_op < 3'd3) n_popped++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_valid = '0; cmd_op = '0; cmd_var = '0; cmd_val = '0;
        mb_valid = 1'b0; decay = 1'b0; flush = 1'b0;
    endtask

    task automatic drive_cmd(input logic [1:0] v, input logic [3:0] ops,
                             input logic [63:0] vars, input logic [1:0] vals);
        logic [1:0] op;
        cmd_valid = v; cmd_op = ops; cmd_var = vars; cmd_val = vals;
        if (!flush && (n_pushed - n_popped) <= 254) begin
            for (int l = 0; l < 2; l++) begin
                op = ops[2*l +: 2];
                if (v[l] && op != 2'd3) begin
                    exp_q.push_back({1'b0, op, vars[32*l +: 32], (op == 2'd0) ? vals[l] : 1'b0, 4'd0});
                    n_pushed++;
                end
            end
        end
    endtask

    task automatic drain(input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (idle && exp_q.size() == 0) done = 1'b1;
            step();
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        n_pushed = n_popped;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        heap_busy = 1'b0;
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL reset_h_valid: got %b expected 0", h_valid); end
        checks++; if (fifo_level !== 9'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (mb_ready !== 1'b1) begin errors++; $display("FAIL reset_mb_ready: got %b expected 1", mb_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_err); end
        step();
    endtask

    task automatic test_two_lanes();
        drive_cmd(2'b11, {2'd1, 2'd0}, {32'd9, 32'd5}, 2'b01);
        @(negedge clk);
        checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL latency: h_valid=%b in accept cycle, expected 0", h_valid); end
        step();
        clear_inputs();
        step();
        step();
        @(negedge clk);
        checks++;
        if (idle !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL two_lanes_idle: idle=%b pending=%0d, expected idle=1 pending=0", idle, exp_q.size());
        end
        step();
    endtask

    task automatic test_compaction();
        bit done;
        drive_cmd(2'b10, {2'd2, 2'd0}, {32'd7, 32'd0}, 2'b00);
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (fifo_level !== 9'd1) begin errors++; $display("FAIL compact_level: got %0d expected 1", fifo_level); end
        step();
        drive_cmd(2'b11, {2'd0, 2'd3}, {32'd11, 32'd4}, 2'b10);
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (fifo_level !== 9'd1) begin errors++; $display("FAIL drop_op3_level: got %0d expected 1", fifo_level); end
        step();
        drain(20, done);
        checks++; if (!done) begin errors++; $display("FAIL compact_drain: pending=%0d expected 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        bit done;
        heap_busy = 1'b1;
        for (int i = 0; i < 127; i++) begin
            drive_cmd(2'b11, {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))},
                      {$urandom(), $urandom()}, 2'($urandom_range(0, 3)));
            step();
        end
        drive_cmd(2'b01, {2'd0, 2'd2}, {32'd0, 32'd77}, 2'b00);
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (fifo_level !== 9'd255) begin errors++; $display("FAIL fill_level: got %0d expected 255", fifo_level); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_cmd_ready: got %b expected 0", cmd_ready); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL early_overflow: got %b expected 0", overflow_err); end
        step();
        drive_cmd(2'b11, {2'd0, 2'd0}, {32'd123, 32'd124}, 2'b11);
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", overflow_err); end
        checks++; if (fifo_level !== 9'd255) begin errors++; $display("FAIL overflow_level: got %0d expected 255", fifo_level); end
        step();
        heap_busy = 1'b0;
        drain(400, done);
        checks++; if (!done) begin errors++; $display("FAIL full_drain: pending=%0d expected 0", exp_q.size()); end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b expected 1", overflow_err); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b expected 0", overflow_err); end
        step();
    endtask

    task automatic test_starve();
        logic [255:0] bv;
        int n_fifo;
        bit seen, done;
        bv = '0;
        bv[95:0] = {32'd3, 32'd2, 32'd1};
        heap_busy = 1'b1;
        mb_valid = 1'b1; mb_count = 4'd3; mb_vars = bv;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(2'b11, {2'd2, 2'd1}, {32'(100 + 2*i + 1), 32'(100 + 2*i)}, 2'b00);
            step();
            mb_valid = 1'b0;
        end
        clear_inputs();
        exp_q.insert(4, {3'd3, 32'd0, 1'b0, 4'd3});
        @(negedge clk);
        checks++; if (mb_ready !== 1'b0) begin errors++; $display("FAIL mb_held: mb_ready=%b expected 0", mb_ready); end
        step();
        heap_busy = 1'b0;
        n_fifo = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (h_valid && h_op == 3'd3) begin
                seen = 1'b1;
                checks++; if (n_fifo != 4) begin errors++; $display("FAIL starve_count: multibump after %0d fifo ops, expected 4", n_fifo); end
                checks++; if (h_bump_vars !== bv) begin errors++; $display("FAIL bump_vars: got %h expected %h", h_bump_vars[95:0], bv[95:0]); end
            end else if (h_valid) begin
                n_fifo++;
            end
            step();
        end
        checks++; if (!seen) begin errors++; $display("FAIL starve_timeout: multibump issued=0 expected 1"); end
        @(negedge clk);
        checks++; if (mb_ready !== 1'b1) begin errors++; $display("FAIL mb_ready_after: got %b expected 1", mb_ready); end
        step();
        drain(20, done);
        checks++; if (!done) begin errors++; $display("FAIL starve_drain: pending=%0d expected 0", exp_q.size()); end
    endtask

    task automatic test_decay();
        bit done;
        heap_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            decay = 1'b1;
            step();
            exp_q.push_back({3'd4, 32'd0, 1'b0, 4'd0});
        end
        decay = 1'b0;
        @(negedge clk);
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL decay_pending_idle: got %b expected 0", idle); end
        step();
        heap_busy = 1'b0;
        drain(20, done);
        checks++; if (!done) begin errors++; $display("FAIL decay3_drain: pending=%0d expected 0", exp_q.size()); end
        heap_busy = 1'b1;
        for (int i = 0; i < 15; i++) begin
            decay = 1'b1;
            step();
            exp_q.push_back({3'd4, 32'd0, 1'b0, 4'd0});
        end
        decay = 1'b0;
        @(negedge clk);
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL decay15_overflow: got %b expected 0", overflow_err); end
        step();
        decay = 1'b1;
        step();
        decay = 1'b0;
        @(negedge clk);
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL decay16_overflow: got %b expected 1", overflow_err); end
        step();
        heap_busy = 1'b0;
        drain(40, done);
        checks++; if (!done) begin errors++; $display("FAIL decay15_drain: pending=%0d expected 0", exp_q.size()); end
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_flush();
        heap_busy = 1'b1;
        mb_valid = 1'b1; mb_count = 4'd2; mb_vars = 256'h0000_0005_0000_0004;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(2'b11, {2'd0, 2'd2}, {32'(200 + i), 32'(300 + i)}, 2'b11);
            step();
            mb_valid = 1'b0;
        end
        clear_inputs();
        @(negedge clk);
        checks++; if (fifo_level !== 9'd10 || mb_ready !== 1'b0) begin errors++; $display("FAIL flush_setup: level=%0d mb_ready=%b expected 10/0", fifo_level, mb_ready); end
        step();
        flush = 1'b1;
        heap_busy = 1'b0;
        drive_cmd(2'b11, {2'd0, 2'd0}, {32'd1, 32'd2}, 2'b00);
        @(negedge clk);
        checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle_issue: h_valid=%b expected 0", h_valid); end
        step();
        clear_inputs();
        model_reset();
        @(negedge clk);
        checks++; if (fifo_level !== 9'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", fifo_level); end
        checks++; if (mb_ready !== 1'b1) begin errors++; $display("FAIL flush_mb_ready: got %b expected 1", mb_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL flush_idle: got %b expected 1", idle); end
        step();
    endtask

    task automatic test_reset_mid();
        drive_cmd(2'b11, {2'd0, 2'd0}, {32'd21, 32'd20}, 2'b11);
        step();
        clear_inputs();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL async_reset_h_valid: got %b expected 0", h_valid); end
        checks++; if (fifo_level !== 9'd0) begin errors++; $display("FAIL async_reset_level: got %0d expected 0", fifo_level); end
        model_reset();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        bit done;
        for (int i = 0; i < 300; i++) begin
            heap_busy = ($urandom_range(0, 3) == 0);
            checks++;
            if (fifo_level !== 9'(n_pushed - n_popped)) begin
                errors++;
                $display("FAIL b2b_level: got %0d expected %0d", fifo_level, n_pushed - n_popped);
            end
            drive_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                      {$urandom(), $urandom()}, 2'($urandom_range(0, 3)));
            step();
        end
        clear_inputs();
        heap_busy = 1'b0;
        drain(700, done);
        checks++; if (!done) begin errors++; $display("FAIL b2b_drain: pending=%0d expected 0", exp_q.size()); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow_err); end
    endtask

    initial begin
        test_reset();
        test_two_lanes();
        test_compaction();
        test_overflow();
        test_starve();
        test_decay();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
